// File: rtl/apu_pkg.sv
// rtl/apu_pkg.sv - frame sequencer mode type, per-step action masks and step length helper.
package apu_pkg;

    typedef enum logic {
        MODE_4STEP = 1'b0,
        MODE_5STEP = 1'b1
    } frame_mode_t;

    // One bit per step index, bit n = action taken when step n's period ends.
    localparam logic [4:0] Q_MASK_4   = 5'b01111;
    localparam logic [4:0] H_MASK_4   = 5'b01010;
    localparam logic [4:0] IRQ_MASK_4 = 5'b01000;
    localparam logic [4:0] Q_MASK_5   = 5'b10111;
    localparam logic [4:0] H_MASK_5   = 5'b10010;

    localparam logic [2:0] LAST_STEP_4 = 3'd3;
    localparam logic [2:0] LAST_STEP_5 = 3'd4;

    function automatic int step_cycles(input int clk_hz, input int step_hz);
        return clk_hz / step_hz;
    endfunction

endpackage

// File: rtl/frame_prescaler.sv
// rtl/frame_prescaler.sv - modulo-STEP_CYCLES counter flagging the last cycle of each step.
module frame_prescaler #(
    parameter int STEP_CYCLES = 7457
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic wrap
);

    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    assign wrap = (count_q == LAST);

    always_comb begin
        count_d = count_q + CW'(1);
        if (clear || wrap) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - APU frame counter: 4/5-step sequencing, quarter/half-frame strobes.
// Define FRAME_IRQ_EN to build the frame interrupt flag, irq_inhibit bit and irq_ack.
module frame_sequencer
    import apu_pkg::*;
#(
    parameter int CLK_HZ  = 1_789_773,
    parameter int STEP_HZ = 240
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] reg_4017,
    input  logic       reg_event,
    input  logic       irq_ack,
    output logic       enable_240hz,
    output logic       enable_120hz,
    output logic       frame_irq
);

    localparam int STEP_CYCLES = step_cycles(CLK_HZ, STEP_HZ);

    frame_mode_t mode_q, mode_d;
    logic [2:0]  step_q, step_d;
    logic        q_q, q_d;
    logic        h_q, h_d;
    logic        irq_set;
    logic        wrap;
    logic        unused_bits;
    frame_mode_t new_mode;

    assign new_mode = frame_mode_t'(reg_4017[7]);

    frame_prescaler #(.STEP_CYCLES(STEP_CYCLES)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (reg_event),
        .wrap  (wrap)
    );

    // A register write overrides a coincident wrap: its step actions are dropped.
    always_comb begin
        mode_d  = mode_q;
        step_d  = step_q;
        q_d     = 1'b0;
        h_d     = 1'b0;
        irq_set = 1'b0;
        if (reg_event) begin
            mode_d = new_mode;
            step_d = 3'd0;
            if (new_mode == MODE_5STEP) begin
                q_d = 1'b1;
                h_d = 1'b1;
            end
        end else if (wrap) begin
            if (mode_q == MODE_5STEP) begin
                q_d    = Q_MASK_5[step_q];
                h_d    = H_MASK_5[step_q];
                step_d = (step_q >= LAST_STEP_5) ? 3'd0 : step_q + 3'd1;
            end else begin
                q_d     = Q_MASK_4[step_q];
                h_d     = H_MASK_4[step_q];
                irq_set = IRQ_MASK_4[step_q];
                step_d  = (step_q >= LAST_STEP_4) ? 3'd0 : step_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_4STEP;
            step_q <= 3'd0;
            q_q    <= 1'b0;
            h_q    <= 1'b0;
        end else begin
            mode_q <= mode_d;
            step_q <= step_d;
            q_q    <= q_d;
            h_q    <= h_d;
        end
    end

    assign enable_240hz = q_q;
    assign enable_120hz = h_q;

`ifdef FRAME_IRQ_EN
    logic irq_q, irq_d;
    logic irq_inhibit_q, irq_inhibit_d;

    // Clear sources are applied first so a same-cycle set takes priority.
    always_comb begin
        irq_inhibit_d = reg_event ? reg_4017[6] : irq_inhibit_q;
        irq_d         = irq_q;
        if (irq_ack || (reg_event && reg_4017[6])) begin
            irq_d = 1'b0;
        end
        if (irq_set && !irq_inhibit_q) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q         <= 1'b0;
            irq_inhibit_q <= 1'b0;
        end else begin
            irq_q         <= irq_d;
            irq_inhibit_q <= irq_inhibit_d;
        end
    end

    assign frame_irq   = irq_q;
    assign unused_bits = ^reg_4017[5:0];
`else
    assign frame_irq   = 1'b0;
    assign unused_bits = ^{reg_4017[6:0], irq_ack, irq_set};
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - directed bench for frame_sequencer at STEP_CYCLES=10.
module tb_frame_sequencer;

`ifdef FRAME_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] reg_4017 = 8'h00;
    logic       reg_event = 1'b0;
    logic       irq_ack = 1'b0;
    logic       enable_240hz;
    logic       enable_120hz;
    logic       frame_irq;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected state: mode, inhibit, irq flag, cycles since reset release or last write.
    bit m_mode = 1'b0;
    bit m_inh  = 1'b0;
    bit m_irq  = 1'b0;
    int m_ph   = 0;

    always #5 clk = ~clk;

    frame_sequencer #(.CLK_HZ(2400), .STEP_HZ(240)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reg_4017     (reg_4017),
        .reg_event    (reg_event),
        .irq_ack      (irq_ack),
        .enable_240hz (enable_240hz),
        .enable_120hz (enable_120hz),
        .frame_irq    (frame_irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (ph=%0d t=%0t)", tag, got, exp, m_ph, $time);
        end
    endtask

    task automatic tick_check(input string tag);
        bit ev, ack, q, h, set;
        logic [7:0] d;
        int k;
        @(posedge clk);
        ev  = reg_event;
        ack = irq_ack;
        d   = reg_4017;
        #1;
        if (ev) begin
            m_mode = d[7];
            m_ph   = 0;
        end else begin
            m_ph++;
        end
        k   = m_ph / 10;
        q   = 1'b0;
        h   = 1'b0;
        set = 1'b0;
        if (m_ph % 10 == 0) begin
            if (!m_mode) begin
                if (m_ph > 0) begin
                    q   = 1'b1;
                    h   = (k % 2 == 0);
                    set = (k % 4 == 0);
                end
            end else begin
                q = (k % 5 != 4);
                h = (k % 5 == 2) || (k % 5 == 0);
            end
        end
        if (IRQ_EN) begin
            if (ack || (ev && d[6])) m_irq = 1'b0;
            if (set && !m_inh) m_irq = 1'b1;
            if (ev) m_inh = d[6];
        end
        check_eq(tag, {29'd0, enable_240hz, enable_120hz, frame_irq}, {29'd0, q, h, m_irq});
    endtask

    task automatic run(input int n, input string tag);
        repeat (n) tick_check(tag);
    endtask

    task automatic write_reg(input logic [7:0] d, input string tag);
        reg_4017  = d;
        reg_event = 1'b1;
        tick_check(tag);
        reg_event = 1'b0;
        reg_4017  = 8'h00;
    endtask

    task automatic ack_irq(input string tag);
        irq_ack = 1'b1;
        tick_check(tag);
        irq_ack = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_q", {31'd0, enable_240hz}, 32'd0);
        check_eq("reset_h", {31'd0, enable_120hz}, 32'd0);
        check_eq("reset_irq", {31'd0, frame_irq}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(45, "four_step");
        ack_irq("irq_ack");
        run(33, "four_step_acked");
        ack_irq("ack_vs_set");
        run(5, "irq_held");

        write_reg(8'h40, "inhibit_write");
        run(130, "inhibited");

        write_reg(8'h80, "five_step_write");
        run(110, "five_step");

        write_reg(8'h00, "four_step_write");
        run(29, "before_wrap");
        write_reg(8'h00, "write_on_wrap");
        run(50, "after_wrap_write");

        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_q", {31'd0, enable_240hz}, 32'd0);
        check_eq("async_reset_h", {31'd0, enable_120hz}, 32'd0);
        check_eq("async_reset_irq", {31'd0, frame_irq}, 32'd0);
        m_mode = 1'b0;
        m_inh  = 1'b0;
        m_irq  = 1'b0;
        m_ph   = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run(45, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
